// File: rtl/vga_pkg.sv
// Shared VGA timing constants and board types for the game logic, timing generator and painter.
// Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_pkg;

    localparam int unsigned CNT_W     = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [3:0]    tile_t;
    typedef tile_t [15:0]  board_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface from the timing generator (master) to the screen painter (slave).
// Carries the live counters, the visible-area flag and the per-frame board snapshot.
interface vga_timing_gen_if
    import vga_pkg::*;
();

    logic [CNT_W-1:0] hs;
    logic [CNT_W-1:0] vs;
    logic             blank_n;
    logic             frame_start;
    board_t           states;
    logic             win;
    logic             lose;

    modport master (
        output hs, vs, blank_n, frame_start, states, win, lose
    );

    modport slave (
        input hs, vs, blank_n, frame_start, states, win, lose
    );

endinterface

// File: rtl/wrap_counter.sv
// Enabled up-counter wrapping at MAX; carry flags the enabled wrap so counters can be chained.
// next exposes the post-edge value so callers can register decodes aligned with count.
module wrap_counter #(
    parameter int unsigned W   = 10,
    parameter int unsigned MAX = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] next,
    output logic         carry
);

    always_comb begin
        carry = en && (count == W'(MAX));
        next  = count;
        if (en) begin
            next = carry ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: 25 MHz pixel enable from the 50 MHz clock, h/v counters, sync/blank
// decode and a board snapshot taken on entry to vblank so each frame draws a stable board.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  board_t            states_in,
    input  logic              win_in,
    input  logic              lose_in,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_n,
    output logic              vga_clk,
    vga_timing_gen_if.master  pix
);

    localparam int unsigned HLAST    = H_VISIBLE + H_FP + H_SYNC + H_BP - 1;
    localparam int unsigned VLAST    = V_VISIBLE + V_FP + V_SYNC + V_BP - 1;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC - 1;

    logic             pix_en;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_carry;
    logic             v_carry;
    logic             hsync_d;
    logic             vsync_d;
    logic             blank_n_d;
    logic             snap;

    wrap_counter #(
        .W   (CNT_W),
        .MAX (HLAST)
    ) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (pix.hs),
        .next  (h_next),
        .carry (h_carry)
    );

    wrap_counter #(
        .W   (CNT_W),
        .MAX (VLAST)
    ) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .en    (h_carry),
        .count (pix.vs),
        .next  (v_next),
        .carry (v_carry)
    );

    // Decode from the next count so the registered flags line up with hs/vs.
    always_comb begin
        hsync_d   = !((h_next >= CNT_W'(HS_START)) && (h_next <= CNT_W'(HS_END)));
        vsync_d   = !((v_next >= CNT_W'(VS_START)) && (v_next <= CNT_W'(VS_END)));
        blank_n_d = (h_next < CNT_W'(H_VISIBLE)) && (v_next < CNT_W'(V_VISIBLE));
        snap      = h_carry && (pix.vs == CNT_W'(V_VISIBLE - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_en          <= 1'b0;
            hsync           <= 1'b1;
            vsync           <= 1'b1;
            pix.blank_n     <= 1'b1;
            pix.frame_start <= 1'b0;
            pix.states      <= '0;
            pix.win         <= 1'b0;
            pix.lose        <= 1'b0;
        end else begin
            pix_en          <= ~pix_en;
            hsync           <= hsync_d;
            vsync           <= vsync_d;
            pix.blank_n     <= blank_n_d;
            pix.frame_start <= h_carry && v_carry;
            if (snap) begin
                pix.states <= states_in;
                pix.win    <= win_in;
                pix.lose   <= lose_in;
            end
        end
    end

    assign vga_clk = pix_en;
    assign sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-width line timing with a shortened vertical frame
// (8 visible lines, 15 total) so several frames and snapshots fit in a short run.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int unsigned TV_VISIBLE = 8;
    localparam int unsigned TV_FP      = 2;
    localparam int unsigned TV_SYNC    = 2;
    localparam int unsigned TV_BP      = 3;

    logic   clk = 1'b0;
    logic   clk_run = 1'b1;
    logic   reset = 1'b0;
    board_t states_in = '0;
    logic   win_in = 1'b0;
    logic   lose_in = 1'b0;
    logic   hsync, vsync, sync_n, vga_clk;

    vga_timing_gen_if pix ();

    vga_timing_gen #(
        .V_VISIBLE (TV_VISIBLE),
        .V_FP      (TV_FP),
        .V_SYNC    (TV_SYNC),
        .V_BP      (TV_BP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .states_in (states_in),
        .win_in    (win_in),
        .lose_in   (lose_in),
        .hsync     (hsync),
        .vsync     (vsync),
        .sync_n    (sync_n),
        .vga_clk   (vga_clk),
        .pix       (pix.master)
    );

    initial forever #5 clk = clk_run ? ~clk : 1'b0;

    typedef struct {
        int          cyc;
        logic        drive;
        logic [63:0] s_in;
        logic        w_in;
        logic        l_in;
        logic [9:0]  hs;
        logic [9:0]  vs;
        logic        hsync;
        logic        vsync;
        logic        blank_n;
        logic        fs;
        logic        vclk;
        logic [63:0] st;
        logic        win;
        logic        lose;
    } vec_t;

    localparam logic [63:0] BRD_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] BRD_B = 64'hFFFF_0000_FFFF_0000;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   fs_count = 0;
    int   fs_last = -1;

    always @(posedge clk) begin
        #1;
        if (pix.frame_start) begin
            fs_count++;
            fs_last = edges;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (edges < target) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    function automatic vec_t mk(input int cyc, input logic drive, input logic [63:0] s_in,
                                input logic w_in, input logic l_in, input int hs, input int vs,
                                input logic hsy, input logic vsy, input logic bn,
                                input logic fs, input logic vclk, input logic [63:0] st,
                                input logic win, input logic lose);
        vec_t v;
        v.cyc = cyc;      v.drive = drive;      v.s_in = s_in;
        v.w_in = w_in;    v.l_in = l_in;
        v.hs = 10'(hs);   v.vs = 10'(vs);
        v.hsync = hsy;    v.vsync = vsy;        v.blank_n = bn;
        v.fs = fs;        v.vclk = vclk;
        v.st = st;        v.win = win;          v.lose = lose;
        return v;
    endfunction

    initial begin
        //                cyc  drv s_in   w  l   hs   vs hsy vsy bn fs vck states  win lose
        vq.push_back(mk(    0, 0, 64'h0,  0, 0,   0,  0, 1, 1, 1, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk(    1, 0, 64'h0,  0, 0,   0,  0, 1, 1, 1, 0, 1, 64'h0, 0, 0));
        vq.push_back(mk(    2, 0, 64'h0,  0, 0,   1,  0, 1, 1, 1, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk(    4, 0, 64'h0,  0, 0,   2,  0, 1, 1, 1, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1279, 0, 64'h0,  0, 0, 639,  0, 1, 1, 1, 0, 1, 64'h0, 0, 0));
        vq.push_back(mk( 1280, 0, 64'h0,  0, 0, 640,  0, 1, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1311, 0, 64'h0,  0, 0, 655,  0, 1, 1, 0, 0, 1, 64'h0, 0, 0));
        vq.push_back(mk( 1312, 0, 64'h0,  0, 0, 656,  0, 0, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1502, 0, 64'h0,  0, 0, 751,  0, 0, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1504, 0, 64'h0,  0, 0, 752,  0, 1, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1598, 0, 64'h0,  0, 0, 799,  0, 1, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 1600, 0, 64'h0,  0, 0,   0,  1, 1, 1, 1, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk( 3400, 1, BRD_A,  1, 0, 100,  2, 1, 1, 1, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk(12798, 0, 64'h0,  0, 0, 799,  7, 1, 1, 0, 0, 0, 64'h0, 0, 0));
        vq.push_back(mk(12800, 0, 64'h0,  0, 0,   0,  8, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(14400, 1, BRD_B,  0, 1,   0,  9, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(15998, 0, 64'h0,  0, 0, 799,  9, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(16000, 0, 64'h0,  0, 0,   0, 10, 1, 0, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(19198, 0, 64'h0,  0, 0, 799, 11, 1, 0, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(19200, 0, 64'h0,  0, 0,   0, 12, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(23998, 0, 64'h0,  0, 0, 799, 14, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(23999, 0, 64'h0,  0, 0, 799, 14, 1, 1, 0, 0, 1, BRD_A, 1, 0));
        vq.push_back(mk(24000, 0, 64'h0,  0, 0,   0,  0, 1, 1, 1, 1, 0, BRD_A, 1, 0));
        vq.push_back(mk(24001, 0, 64'h0,  0, 0,   0,  0, 1, 1, 1, 0, 1, BRD_A, 1, 0));
        vq.push_back(mk(36798, 0, 64'h0,  0, 0, 799,  7, 1, 1, 0, 0, 0, BRD_A, 1, 0));
        vq.push_back(mk(36800, 0, 64'h0,  0, 0,   0,  8, 1, 1, 0, 0, 0, BRD_B, 0, 1));

        // Reset held with the clock running, then released between edges.
        #23;
        chk("rst_hs", -1, 64'(pix.hs), 64'd0);
        chk("rst_hsync", -1, 64'(hsync), 64'd1);
        reset = 1'b1;
        edges = 0;
        chk("sync_n", -1, 64'(sync_n), 64'd0);

        foreach (vq[i]) begin
            run_to(vq[i].cyc);
            chk("hs",          i, 64'(pix.hs),          64'(vq[i].hs));
            chk("vs",          i, 64'(pix.vs),          64'(vq[i].vs));
            chk("hsync",       i, 64'(hsync),           64'(vq[i].hsync));
            chk("vsync",       i, 64'(vsync),           64'(vq[i].vsync));
            chk("blank_n",     i, 64'(pix.blank_n),     64'(vq[i].blank_n));
            chk("frame_start", i, 64'(pix.frame_start), 64'(vq[i].fs));
            chk("vga_clk",     i, 64'(vga_clk),         64'(vq[i].vclk));
            chk("states",      i, 64'(pix.states),      vq[i].st);
            chk("win",         i, 64'(pix.win),         64'(vq[i].win));
            chk("lose",        i, 64'(pix.lose),        64'(vq[i].lose));
            if (vq[i].drive) begin
                states_in = vq[i].s_in;
                win_in    = vq[i].w_in;
                lose_in   = vq[i].l_in;
            end
        end

        // One frame_start per 24000 clk in the shortened frame.
        run_to(48002);
        chk("fs_count", -1, 64'(fs_count), 64'd2);
        chk("fs_last",  -1, 64'(fs_last),  64'd48000);

        // Mid-frame reset with the clock stopped.
        run_to(56600);
        chk("pre_rst_hs", -1, 64'(pix.hs), 64'd300);
        chk("pre_rst_vs", -1, 64'(pix.vs), 64'd5);
        clk_run = 1'b0;
        #20;
        reset = 1'b0;
        #1;
        chk("mrst_hs",      -1, 64'(pix.hs),          64'd0);
        chk("mrst_vs",      -1, 64'(pix.vs),          64'd0);
        chk("mrst_hsync",   -1, 64'(hsync),           64'd1);
        chk("mrst_vsync",   -1, 64'(vsync),           64'd1);
        chk("mrst_blank_n", -1, 64'(pix.blank_n),     64'd1);
        chk("mrst_vga_clk", -1, 64'(vga_clk),         64'd0);
        chk("mrst_fs",      -1, 64'(pix.frame_start), 64'd0);
        chk("mrst_states",  -1, 64'(pix.states),      64'd0);
        chk("mrst_win",     -1, 64'(pix.win),         64'd0);
        chk("mrst_lose",    -1, 64'(pix.lose),        64'd0);
        #10;
        reset = 1'b1;
        #3;
        edges = 0;
        clk_run = 1'b1;
        run_to(1);
        chk("rel_hs1", -1, 64'(pix.hs), 64'd0);
        run_to(2);
        chk("rel_hs2", -1, 64'(pix.hs), 64'd1);
        run_to(4);
        chk("rel_hs4", -1, 64'(pix.hs), 64'd2);
        chk("rel_vs4", -1, 64'(pix.vs), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
